inv_sbox_layer_seq: RTL and testbench
=====================================

INV_SBOX_LAYER_SEQ -- requirements
Module: inv_sbox_layer_seq

Interface
REQ-001 The block SHALL have parameter NUM_SYMBOLS, default 8, giving the number of 5-bit symbols per block; legal values are even, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream block is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a new input block.
REQ-006 The block SHALL have port in_data, input, 5*NUM_SYMBOLS bits: ciphertext block; symbol i occupies bits [5i+4:5i].
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a finished block.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-009 The block SHALL have port out_data, output, 5*NUM_SYMBOLS bits: inverse-substituted block, same symbol layout.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 The block SHALL map each symbol y to x with S(x)=y, using the inverse table for y=0..31: 27,6,30,1,5,23,13,26,7,31,0,2,8,19,20,16,28,4,11,21,15,29,3,10,17,24,12,25,9,18,22,14.
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1; when in_valid&in_ready is high at an edge, the block SHALL load in_data into the working register, clear the symbol counter and go to RUN.
REQ-014 RUN: on each edge the block SHALL replace symbol[count] with its inverse, increment count, and go to DONE on the edge that processes symbol NUM_SYMBOLS-1.
REQ-015 Processing order SHALL be symbol 0 first, ascending.
REQ-016 DONE: out_valid=1 and out_data is the working register; when out_valid&out_ready is high at an edge, the block SHALL return to IDLE.
REQ-017 Latency: out_valid SHALL rise NUM_SYMBOLS edges after the accepting edge; throughput is one block per NUM_SYMBOLS+2 cycles minimum.
REQ-018 in_ready SHALL be 0 in RUN and DONE; there is no accept in the same cycle as the output handshake.
REQ-019 While out_valid=1 and out_ready=0, out_data SHALL remain stable and the FSM SHALL stay in DONE indefinitely.
REQ-020 in_data and in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-021 out_data SHALL be valid only when out_valid=1; its value at other times is the working register (don't-care for consumers).

Reset
REQ-022 While rst_n=0 the block SHALL force state=IDLE, count=0, working register=0, out_valid=0, busy=0 and in_ready=1 (after release).
REQ-023 Assertion of rst_n in RUN or DONE SHALL discard the in-flight block with no output handshake.
REQ-024 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 With macro INV_SBOX_UNROLL2_EN defined, RUN SHALL process two symbols per edge (symbols 2k and 2k+1), giving latency NUM_SYMBOLS/2 edges.
REQ-026 Without INV_SBOX_UNROLL2_EN, the block SHALL use one inverse-table instance and one symbol per edge, as in REQ-014.
REQ-027 Output values and handshake rules SHALL be identical in both builds; only latency differs.

Verification
REQ-028 Default config: in_data=40'h5294A5294A (all symbols 10), accepted -> out_valid after 8 edges (4 edges in the UNROLL2 build), out_data=40'h0.
REQ-029 Symbols 0..7 = 0,1,2,3,4,5,6,7 -> out symbols 27,6,30,1,5,23,13,26.
REQ-030 Exhaustive round trip: 32 blocks built from the forward sBox output of every 5-bit value -> every output symbol equals the original value.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data is stable, in_ready=0; block completes on the first cycle out_ready=1.
REQ-032 Pulse rst_n low at RUN count=3 -> out_valid=0 and in_ready=1 after release, with no spurious output; the next block processes correctly.
REQ-033 Hold in_valid high continuously with back-to-back blocks and out_ready=1 -> accepts are spaced NUM_SYMBOLS+2 cycles apart with no lost or duplicated blocks.

Source files
------------

// File: rtl/inv_sbox_layer_seq.sv
// Sequential inverse 5-bit S-box layer.
// A block of NUM_SYMBOLS 5-bit symbols is loaded in IDLE, inverse-substituted
// symbol by symbol (ascending) in RUN and presented with a valid/ready
// handshake in DONE.
// Optional build macro: INV_SBOX_UNROLL2_EN -- process symbols 2k and 2k+1 per
// edge, halving latency; results and handshake behaviour are unchanged.
module inv_sbox_layer_seq #(
  parameter int unsigned NUM_SYMBOLS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5*NUM_SYMBOLS-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5*NUM_SYMBOLS-1:0]   out_data,
  output logic                       busy
);

  localparam int unsigned W    = 5 * NUM_SYMBOLS;
  localparam int unsigned CntW = (NUM_SYMBOLS > 2) ? $clog2(NUM_SYMBOLS) : 1;
`ifdef INV_SBOX_UNROLL2_EN
  localparam int Steps = int'(NUM_SYMBOLS / 2);
`else
  localparam int Steps = int'(NUM_SYMBOLS);
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  // InvTable[y] = x such that S(x) = y
  localparam logic [4:0] InvTable [32] = '{
    5'd27, 5'd6,  5'd30, 5'd1,  5'd5,  5'd23, 5'd13, 5'd26,
    5'd7,  5'd31, 5'd0,  5'd2,  5'd8,  5'd19, 5'd20, 5'd16,
    5'd28, 5'd4,  5'd11, 5'd21, 5'd15, 5'd29, 5'd3,  5'd10,
    5'd17, 5'd24, 5'd12, 5'd25, 5'd9,  5'd18, 5'd22, 5'd14
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          st_q, st_d;
  logic [CntW-1:0] count_q, count_d;
  logic [W-1:0]    work_q, work_d;
  logic [4:0]      sym0_in, sym0_out;
`ifdef INV_SBOX_UNROLL2_EN
  logic [4:0]      sym1_in, sym1_out;
`endif

  // Route the symbol(s) addressed by count into the shared lookup(s)
  always_comb begin
    sym0_in = '0;
`ifdef INV_SBOX_UNROLL2_EN
    sym1_in = '0;
    for (int k = 0; k < Steps; k++) begin
      if (count_q == CntW'(k)) begin
        sym0_in = work_q[10*k +: 5];
        sym1_in = work_q[10*k+5 +: 5];
      end
    end
`else
    for (int i = 0; i < Steps; i++) begin
      if (count_q == CntW'(i)) sym0_in = work_q[5*i +: 5];
    end
`endif
  end

  assign sym0_out = InvTable[sym0_in];
`ifdef INV_SBOX_UNROLL2_EN
  assign sym1_out = InvTable[sym1_in];
`endif

  // Next-state logic: load, substitute in place, hold until drained
  always_comb begin
    st_d    = st_q;
    count_d = count_q;
    work_d  = work_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
          count_d = '0;
          st_d    = StRun;
        end
      end
      StRun: begin
        for (int j = 0; j < Steps; j++) begin
          if (count_q == CntW'(j)) begin
`ifdef INV_SBOX_UNROLL2_EN
            work_d[10*j +: 5]   = sym0_out;
            work_d[10*j+5 +: 5] = sym1_out;
`else
            work_d[5*j +: 5]    = sym0_out;
`endif
          end
        end
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) st_d = StDone;
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  // State, counter and working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      count_q <= '0;
      work_q  <= '0;
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (st_q == StIdle);
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sbox_layer_seq.sv
// Scoreboard bench for inv_sbox_layer_seq (NUM_SYMBOLS = 8).
`timescale 1ns/1ps
module tb_inv_sbox_layer_seq;

  localparam int N = 8;
  localparam int W = 5 * N;
`ifdef INV_SBOX_UNROLL2_EN
  localparam int LAT = N / 2;
`else
  localparam int LAT = N;
`endif

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] in_data, out_data;

  inv_sbox_layer_seq #(.NUM_SYMBOLS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  bit           b2b = 0;
  bit           have_last = 0;
  int           last_acc = 0;

  int inv_tab [32] = '{27, 6, 30, 1, 5, 23, 13, 26, 7, 31, 0, 2, 8, 19, 20, 16,
                       28, 4, 11, 21, 15, 29, 3, 10, 17, 24, 12, 25, 9, 18, 22, 14};
  int fwd [32];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Accept monitor: records accept cycle, checks back-to-back spacing
  initial forever begin
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc + 1);
      if (b2b && have_last) check("accept_spacing", 64'(cyc + 1 - last_acc), 64'(LAT + 2));
      last_acc  = cyc + 1;
      have_last = 1;
    end
  end

  // Output monitor: latency on out_valid rise, data on handshake
  initial begin : out_mon
    bit prev_ov;
    int a;
    logic [W-1:0] e;
    prev_ov = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
          else begin
            a = acc_q.pop_front();
            check("latency", 64'(cyc - a), 64'(LAT));
          end
        end
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("spurious_output", 64'(out_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e));
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
    wait_ready();
    exp_q.push_back(e);
    in_data  = d;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  logic [W-1:0] d, e;
  int t;
  int exp29 [8] = '{27, 6, 30, 1, 5, 23, 13, 26};
  int exph  [8] = '{14, 22, 18, 9, 25, 12, 24, 17};

  initial begin
    for (int y = 0; y < 32; y++) fwd[inv_tab[y]] = y;
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // All symbols 10 -> all zero; accept on first edge after reset release
    send(40'h5294A5294A, 40'h0);
    drain();

    // Symbols 0..7
    for (int i = 0; i < N; i++) begin
      d[5*i +: 5] = 5'(i);
      e[5*i +: 5] = 5'(exp29[i]);
    end
    send(d, e);
    drain();

    // Backpressure hold in DONE with symbols 31..24
    for (int i = 0; i < N; i++) begin
      d[5*i +: 5] = 5'(31 - i);
      e[5*i +: 5] = 5'(exph[i]);
    end
    out_ready = 0;
    send(d, e);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("hold_reach_done", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_data", 64'(out_data), 64'(e));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("hold_release", 64'(out_valid), 64'd0);
    drain();

    // Reset in the middle of RUN (count = 3)
    send(40'h5294A5294A, 40'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    exp_q.delete();
    acc_q.delete();
    #3;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #3;
    rst_n = 1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid2", 64'(out_valid), 64'd0);
    for (int i = 0; i < N; i++) begin
      d[5*i +: 5] = 5'(i);
      e[5*i +: 5] = 5'(exp29[i]);
    end
    send(d, e);
    drain();

    // Exhaustive round trip, back-to-back with in_valid held high
    b2b = 1;
    have_last = 0;
    in_valid = 1;
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < N; i++) begin
        d[5*i +: 5] = 5'(fwd[(b + i) % 32]);
        e[5*i +: 5] = 5'((b + i) % 32);
      end
      wait_ready();
      exp_q.push_back(e);
      in_data = d;
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    b2b = 0;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_acc_empty", 64'(acc_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
